// File: rtl/skid_register_pkg.sv
// Shared constants for the two-entry skid register slice: state encoding and default width.
package skid_register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned STATE_W       = 2;

    typedef logic [STATE_W-1:0] stateT;

    localparam stateT S_EMPTY = 2'd0;
    localparam stateT S_ONE   = 2'd1;
    localparam stateT S_FULL  = 2'd2;

endpackage

// File: rtl/skid_register_slot.sv
// Data register with load enable, synchronous clear and asynchronous active-low reset to zero.
module skid_slot #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so a flush always empties the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_register.sv
// Two-entry valid/ready pipeline slice; inReady depends only on state, never on outReady.
module skid_register
    import skid_register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       count
);

    stateT            state;
    stateT            stateNext;
    logic             inFire;
    logic             outFire;
    logic             loadMain;
    logic             loadSkid;
    logic             mainFromSkid;
    logic [WIDTH-1:0] mainD;
    logic [WIDTH-1:0] mainQ;
    logic [WIDTH-1:0] skidQ;

    // Handshake outputs are pure decodes of the state register.
    assign outValid = (state != S_EMPTY);
    assign inReady  = (state != S_FULL);
    assign outData  = mainQ;
    assign count    = state;

    assign inFire  = inValid & inReady;
    assign outFire = outValid & outReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        if (flush) begin
            stateNext = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (inFire) begin
                        stateNext = S_ONE;
                        loadMain  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (inFire && outFire) begin
                        loadMain = 1'b1;
                    end else if (inFire) begin
                        stateNext = S_FULL;
                        loadSkid  = 1'b1;
                    end else if (outFire) begin
                        stateNext = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (outFire) begin
                        stateNext    = S_ONE;
                        loadMain     = 1'b1;
                        mainFromSkid = 1'b1;
                    end
                end
                // Encoding 3 is unreachable; fall back to a clean empty slice.
                default: stateNext = S_EMPTY;
            endcase
        end
    end

    assign mainD = mainFromSkid ? skidQ : inData;

    skid_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (loadMain),
        .d     (mainD),
        .q     (mainQ)
    );

    skid_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (loadSkid),
        .d     (inData),
        .q     (skidQ)
    );

endmodule

// File: tb/tb_skid_register.sv
// Directed bench for skid_register: reset, fill/backpressure, streaming, flush races.
module tb_skid_register;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [1:0]       count;

    int checks = 0;
    int errors = 0;

    skid_register #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        #3;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_inReady", 32'(inReady), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_outData", 32'(outData), 32'd0);
        #4 rst = 1'b1;
        step();

        // Test 1: fill to FULL then asynchronous reset between edges
        inValid = 1'b1; inData = 4'hA; step();
        inData = 4'hB; step();
        inValid = 1'b0;
        check("t1_full_count", 32'(count), 32'd2);
        check("t1_full_head", 32'(outData), 32'hA);
        #2 rst = 1'b0;
        #1;
        check("t1_arst_outValid", 32'(outValid), 32'd0);
        check("t1_arst_inReady", 32'(inReady), 32'd1);
        check("t1_arst_count", 32'(count), 32'd0);
        check("t1_arst_outData", 32'(outData), 32'd0);
        step();
        check("t1_held_count", 32'(count), 32'd0);
        rst = 1'b1;
        step();

        // Test 2: single word held while consumer stalls
        inValid = 1'b1; inData = 4'hC; step();
        inValid = 1'b0;
        check("t2_outValid", 32'(outValid), 32'd1);
        check("t2_outData", 32'(outData), 32'hC);
        check("t2_count", 32'(count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_data", 32'(outData), 32'hC);
            check("t2_hold_valid", 32'(outValid), 32'd1);
        end
        outReady = 1'b1; step(); outReady = 1'b0;
        check("t2_drained", 32'(count), 32'd0);

        // Test 3: fill and backpressure
        inValid = 1'b1; inData = 4'h1; step();
        inData = 4'h2; step();
        check("t3_count_full", 32'(count), 32'd2);
        check("t3_inReady_full", 32'(inReady), 32'd0);
        inData = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_bp_data", 32'(outData), 32'h1);
            check("t3_bp_count", 32'(count), 32'd2);
        end
        outReady = 1'b1;
        check("t3_read0", 32'(outData), 32'h1);
        step();
        check("t3_read1", 32'(outData), 32'h2);
        check("t3_read1_count", 32'(count), 32'd1);
        step();
        check("t3_read2", 32'(outData), 32'h3);
        check("t3_read2_count", 32'(count), 32'd1);
        inValid = 1'b0;
        step();
        check("t3_empty", 32'(count), 32'd0);
        outReady = 1'b0;

        // Test 4: streaming at full throughput
        inValid = 1'b1; outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inData = 4'(i);
            step();
            check("t4_data", 32'(outData), 32'(i));
            check("t4_count", 32'(count), 32'd1);
            check("t4_inReady", 32'(inReady), 32'd1);
        end
        inValid = 1'b0; step(); outReady = 1'b0;
        check("t4_empty", 32'(count), 32'd0);

        // Test 5a: flush in FULL together with a read
        inValid = 1'b1; inData = 4'h5; step();
        inData = 4'h6; step();
        inValid = 1'b0;
        check("t5a_full", 32'(count), 32'd2);
        flush = 1'b1; outReady = 1'b1;
        check("t5a_consumed_valid", 32'(outValid), 32'd1);
        check("t5a_consumed_data", 32'(outData), 32'h5);
        step();
        flush = 1'b0; outReady = 1'b0;
        check("t5a_count", 32'(count), 32'd0);
        check("t5a_outValid", 32'(outValid), 32'd0);
        check("t5a_outData", 32'(outData), 32'd0);

        // Test 5b: flush in ONE drops a simultaneously offered word
        inValid = 1'b1; inData = 4'h4; step();
        check("t5b_one", 32'(count), 32'd1);
        flush = 1'b1; inData = 4'h9;
        check("t5b_inReady", 32'(inReady), 32'd1);
        step();
        flush = 1'b0; inValid = 1'b0;
        check("t5b_count", 32'(count), 32'd0);
        check("t5b_outValid", 32'(outValid), 32'd0);
        step();
        check("t5b_stays_empty", 32'(count), 32'd0);

        // Test 6: simultaneous in/out in ONE
        inValid = 1'b1; inData = 4'h7; step();
        check("t6_head7", 32'(outData), 32'h7);
        inData = 4'h8; outReady = 1'b1; step();
        check("t6_head8", 32'(outData), 32'h8);
        check("t6_count", 32'(count), 32'd1);
        check("t6_inReady", 32'(inReady), 32'd1);
        inValid = 1'b0; step();
        check("t6_empty", 32'(count), 32'd0);

        // Empty boundary: read request with nothing held
        step();
        check("empty_read_count", 32'(count), 32'd0);
        check("empty_read_valid", 32'(outValid), 32'd0);
        outReady = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
